// File: rtl/mac_tx_fcs_framer_pkg.sv
// Shared constants, FSM state encoding and CRC-32 helpers for the GMII transmit framer.
package mac_tx_fcs_framer_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PRE_LEN       = 8;
  localparam int          FCS_LEN       = 4;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAD  = 3'd3,
    FCS  = 3'd4,
    IFG  = 3'd5
  } state_t;

  // MSB-first register; each byte is shifted in LSB first, as it goes on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // FCS byte k (k=0 sent first) taken from the frozen CRC register.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
    logic [7:0] s;
    case (k)
      2'd0:    s = crc[31:24];
      2'd1:    s = crc[23:16];
      2'd2:    s = crc[15:8];
      default: s = crc[7:0];
    endcase
    return ~bitrev8(s);
  endfunction

endpackage

// File: rtl/crc32_check.sv
// Byte-wide Ethernet CRC-32 engine: re-seeded by init, advanced by one byte per en cycle.
module crc32_check
  import mac_tx_fcs_framer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/mac_tx_fcs_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, FCS and inter-frame gap.
// tx_valid/tx_ready: a byte transfers on an edge where both are high; tx_ready is high only in DATA, and tx_valid low in DATA is an underrun.
module mac_tx_fcs_framer
  import mac_tx_fcs_framer_pkg::*;
#(
  parameter bit PAD_EN    = 1'b1,
  parameter int MIN_FRAME = 60,
  parameter int IFG_CYC   = 12
) (
  input  logic       reset,
  input  logic       clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output state_t     fsm_state
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [3:0]  PRE_LAST = 4'(PRE_LEN - 1);
  localparam logic [3:0]  FCS_LAST = 4'(FCS_LEN - 1);
  localparam logic [3:0]  IFG_LAST = 4'(IFG_CYC - 1);

  state_t      state, state_n;
  logic [10:0] byte_cnt, cnt_n, cnt_inc;
  logic [3:0]  phase, phase_n;
  logic [7:0]  txd_n;
  logic        en_n, er_n;
  logic        crc_init, crc_en;
  logic [7:0]  crc_in;
  logic [31:0] crc_data;

  crc32_check u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .data  (crc_in),
    .crc   (crc_data)
  );

  assign cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign tx_ready  = (state == DATA);
  assign tx_busy   = (state != IDLE);
  assign fsm_state = state;
  assign crc_in    = (state == PAD) ? 8'h00 : tx_data;

  // The wire byte is registered, so the first preamble byte is launched on the IDLE->PRE edge.
  always_comb begin
    state_n  = state;
    cnt_n    = byte_cnt;
    phase_n  = phase;
    txd_n    = 8'h00;
    en_n     = 1'b0;
    er_n     = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n  = PRE;
          crc_init = 1'b1;
          cnt_n    = 11'd0;
          phase_n  = 4'd1;
          txd_n    = PREAMBLE_BYTE;
          en_n     = 1'b1;
        end
      end
      PRE: begin
        en_n    = 1'b1;
        txd_n   = (phase == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
        phase_n = phase + 4'd1;
        if (phase == PRE_LAST) begin
          state_n = DATA;
          phase_n = 4'd0;
        end
      end
      DATA: begin
        en_n    = 1'b1;
        phase_n = 4'd0;
        if (tx_valid) begin
          txd_n  = tx_data;
          crc_en = 1'b1;
          cnt_n  = cnt_inc;
          if (tx_last) begin
            state_n = (PAD_EN && (cnt_inc < MIN_CNT)) ? PAD : FCS;
          end
        end else begin
          er_n    = 1'b1;
          state_n = IFG;
        end
      end
      PAD: begin
        en_n   = 1'b1;
        crc_en = 1'b1;
        cnt_n  = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          state_n = FCS;
          phase_n = 4'd0;
        end
      end
      FCS: begin
        en_n    = 1'b1;
        txd_n   = fcs_byte(crc_data, phase[1:0]);
        phase_n = phase + 4'd1;
        if (phase == FCS_LAST) begin
          state_n = IFG;
          phase_n = 4'd0;
        end
      end
      IFG: begin
        phase_n = phase + 4'd1;
        if (phase == IFG_LAST) begin
          state_n = IDLE;
          phase_n = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 11'd0;
      phase      <= 4'd0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= cnt_n;
      phase      <= phase_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
    end
  end

endmodule

// File: tb/tb_mac_tx_fcs_framer.sv
// Bench for mac_tx_fcs_framer: one unpadded and one padded instance, checked against a byte-stream model.
module tb_mac_tx_fcs_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data[2];
  logic       tx_valid[2];
  logic       tx_last[2];
  logic       tx_ready[2];
  logic [7:0] gmii_txd[2];
  logic       gmii_tx_en[2];
  logic       gmii_tx_er[2];
  logic       tx_busy[2];
  logic [2:0] fsm_state[2];

  always #4 clk = ~clk;

  mac_tx_fcs_framer #(.PAD_EN(1'b0), .MIN_FRAME(60), .IFG_CYC(12)) dut_nopad (
    .reset(reset), .clk(clk), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_last(tx_last[0]),
    .tx_ready(tx_ready[0]), .gmii_txd(gmii_txd[0]), .gmii_tx_en(gmii_tx_en[0]),
    .gmii_tx_er(gmii_tx_er[0]), .tx_busy(tx_busy[0]), .fsm_state(fsm_state[0])
  );

  mac_tx_fcs_framer #(.PAD_EN(1'b1), .MIN_FRAME(60), .IFG_CYC(12)) dut_pad (
    .reset(reset), .clk(clk), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_last(tx_last[1]),
    .tx_ready(tx_ready[1]), .gmii_txd(gmii_txd[1]), .gmii_tx_en(gmii_tx_en[1]),
    .gmii_tx_er(gmii_tx_er[1]), .tx_busy(tx_busy[1]), .fsm_state(fsm_state[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       en;
    logic       er;
    logic       busy;
    logic [7:0] txd;
  } samp_t;

  samp_t      trace[$];
  int         mon_sel = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    int sel;
    int len;
    int exp_en;
  } vec_t;
  vec_t vecs[8];

  always @(negedge clk) begin
    trace.push_back({gmii_tx_en[mon_sel], gmii_tx_er[mon_sel], tx_busy[mon_sel], gmii_txd[mon_sel]});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: preamble, SFD, payload, zero pad, then reflected CRC-32 of the padded frame, LSB byte first.
  task automatic model_frame(input bit pad_en);
    logic [7:0]  fr[$];
    logic [31:0] crc;
    fr = pay_q;
    if (pad_en) while (fr.size() < 60) fr.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      crc = crc ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (fr[i]) exp_q.push_back(fr[i]);
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
    exp_q.push_back(crc[23:16]);
    exp_q.push_back(crc[31:24]);
  endtask

  task automatic send_bytes(input int sel, input int n);
    int idx   = 0;
    int guard = 0;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      tx_data[sel]  = pay_q[idx];
      tx_valid[sel] = 1'b1;
      tx_last[sel]  = (idx == pay_q.size() - 1);
      if (tx_ready[sel]) idx++;
      guard++;
    end
    if (idx < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, n);
    end
  endtask

  task automatic go_idle(input int sel);
    @(negedge clk);
    tx_valid[sel] = 1'b0;
    tx_last[sel]  = 1'b0;
    tx_data[sel]  = 8'h00;
  endtask

  task automatic wait_idle(input int sel);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_busy[sel] && k < 500);
    if (tx_busy[sel]) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: tx_busy still 1 after %0d cycles, required 0", k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string name, input int exp_en, input int exp_bursts);
    logic [7:0] got_q[$];
    int         n_er   = 0;
    int         bursts = 0;
    logic       prev   = 1'b0;
    int         bad    = -1;
    logic [7:0] gb     = 8'h00;
    logic [7:0] eb     = 8'h00;
    foreach (trace[i]) begin
      if (trace[i].en) got_q.push_back(trace[i].txd);
      if (trace[i].er) n_er++;
      if (trace[i].en && !prev) bursts++;
      prev = trace[i].en;
    end
    check({name, "_en_cycles"}, got_q.size(), exp_en);
    check({name, "_er"}, n_er, 0);
    check({name, "_bursts"}, bursts, exp_bursts);
    n_checks++;
    for (int i = 0; i < exp_q.size() && bad < 0; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
    if (bad >= 0) begin
      n_fail++;
      if (bad < got_q.size()) gb = got_q[bad];
      if (bad < exp_q.size()) eb = exp_q[bad];
      $display("FAIL %s_stream: byte %0d got %0h expected %0h (got %0d bytes, expected %0d)",
               name, bad, gb, eb, got_q.size(), exp_q.size());
    end
  endtask

  task automatic run_frame(input int sel, input string name, input int exp_en, input bit use_model);
    @(posedge clk);
    trace.delete();
    mon_sel = sel;
    if (use_model) begin
      exp_q.delete();
      model_frame(sel == 1);
    end
    send_bytes(sel, pay_q.size());
    go_idle(sel);
    wait_idle(sel);
    check_stream(name, exp_en, 1);
  endtask

  initial begin
    int sel, len, e, last1, first2, zeros, nen;
    logic [7:0] f2[$];

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tx_data[s] = 8'h00; tx_valid[s] = 1'b0; tx_last[s] = 1'b0;
    end

    // Reset state
    #20;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_en_%0d", s), gmii_tx_en[s], 0);
      check($sformatf("rst_er_%0d", s), gmii_tx_er[s], 0);
      check($sformatf("rst_txd_%0d", s), gmii_txd[s], 0);
      check($sformatf("rst_ready_%0d", s), tx_ready[s], 0);
      check($sformatf("rst_busy_%0d", s), tx_busy[s], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Known vector: CRC-32("123456789") = CBF43926
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    run_frame(0, "ascii", 21, 1'b0);

    // Table of frame lengths around the pad boundary
    vecs[0] = '{1, 42, 72};
    vecs[1] = '{1, 60, 72};
    vecs[2] = '{1, 61, 73};
    vecs[3] = '{0, 1, 13};
    vecs[4] = '{1, 1, 72};
    vecs[5] = '{0, 64, 76};
    vecs[6] = '{1, 59, 72};
    vecs[7] = '{0, 100, 112};
    foreach (vecs[v]) begin
      fill_random(vecs[v].len);
      run_frame(vecs[v].sel, $sformatf("vec%0d_len%0d", v, vecs[v].len), vecs[v].exp_en, 1'b1);
    end

    // Random frames
    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 1);
      len = $urandom_range(1, 90);
      fill_random(len);
      run_frame(sel, $sformatf("rand%0d_sel%0d_len%0d", r, sel, len),
                12 + len + ((sel == 1 && len < 60) ? 60 - len : 0), 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Underrun after 20 accepted bytes
    @(posedge clk);
    trace.delete();
    mon_sel = 1;
    fill_random(30);
    send_bytes(1, 20);
    @(negedge clk);
    tx_valid[1] = 1'b0;
    tx_last[1]  = 1'b0;
    wait_idle(1);
    e = -1;
    foreach (trace[i]) if (trace[i].er && e < 0) e = i;
    if (e < 0 || e + 12 >= trace.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL ur_er_seen: er index %0d of %0d samples, required a full underrun window", e, trace.size());
    end else begin
      check("ur_en_with_er", trace[e].en, 1);
      nen = 0;
      for (int i = 0; i < e; i++) if (trace[i].en) nen++;
      check("ur_bytes_before", nen, 28);
      zeros = 0;
      for (int k = 1; k <= 12; k++) if (!trace[e+k].en) zeros++;
      check("ur_idle_cycles", zeros, 12);
      check("ur_busy_in_ifg", trace[e+11].busy, 1);
      check("ur_busy_idle", trace[e+12].busy, 0);
      nen = 0;
      foreach (trace[i]) if (trace[i].er) nen++;
      check("ur_er_count", nen, 1);
    end

    // Back-to-back 64-byte frames, tx_valid held high
    @(posedge clk);
    trace.delete();
    mon_sel = 0;
    exp_q.delete();
    fill_random(64);
    f2 = pay_q;
    model_frame(1'b0);
    send_bytes(0, 64);
    fill_random(64);
    model_frame(1'b0);
    send_bytes(0, 64);
    go_idle(0);
    wait_idle(0);
    check_stream("b2b", 152, 2);
    last1  = -1;
    first2 = -1;
    foreach (trace[i]) begin
      if (last1 < 0 && i > 0 && trace[i-1].en && !trace[i].en) last1 = i - 1;
      if (last1 >= 0 && first2 < 0 && trace[i].en) first2 = i;
    end
    check("b2b_gap", first2 - last1 - 1, 12);

    // Async reset in the middle of the payload
    fill_random(30);
    send_bytes(1, 10);
    @(posedge clk);
    #1;
    check("rst_mid_en_before", gmii_tx_en[1], 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_en", gmii_tx_en[1], 0);
    check("rst_mid_er", gmii_tx_er[1], 0);
    check("rst_mid_txd", gmii_txd[1], 0);
    check("rst_mid_busy", tx_busy[1], 0);
    check("rst_mid_ready", tx_ready[1], 0);
    tx_valid[1] = 1'b0;
    tx_last[1]  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fill_random(30);
    run_frame(1, "after_reset", 72, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
